// File: rtl/dff_share_arbiter_pkg.sv
// Shared types and default sizing for the shared D-FF holding-register arbiter.
package dff_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester-side and downstream handshake bundle for dff_share_arbiter.
interface dff_share_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = $clog2(N);

    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_ready;

    // master drives requests and consumes the held word; slave is the arbiter
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/dff_share_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is honoured.
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] g,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    int             idx;

    // Upper copy is never masked, so any set request is always found there
    // once the lower copy below ptr has been cleared.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int j = 0; j < 2*N; j++) begin
            masked[j] = dbl[j] & ((j >= N) || (j >= int'(ptr)));
        end
    end

    always_comb begin
        idx = 0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (masked[j]) idx = j;
        end
    end

    always_comb begin
        any   = |req;
        g     = (idx >= N) ? SW'(idx - N) : SW'(idx);
        grant = '0;
        if (any) grant[g] = 1'b1;
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin sharing of one W-bit holding register among N requesters.
// Latency: word granted at edge k is presented (out_valid=1) in cycle k+1.
// Backpressure: out_ready=0 while FULL stalls all grants; refill same edge on take.
module dff_share_arbiter
    import dff_arb_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int W  = DEF_W,
    localparam int SW = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    dff_share_arbiter_if.slave  bus
);

    state_t        state, state_nxt;
    logic [SW-1:0] ptr;
    logic [N-1:0]  pick_oh;
    logic [SW-1:0] pick_idx;
    logic          pick_any;
    logic          accept;
    logic          grant_en;
    logic [W-1:0]  hold_data;
    logic [SW-1:0] hold_src;

    rr_pick #(.N(N), .SW(SW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (pick_oh),
        .g     (pick_idx),
        .any   (pick_any)
    );

    assign accept   = (state == EMPTY) || bus.out_ready;
    assign grant_en = accept && pick_any && !reset;

    always_comb begin
        state_nxt     = state;
        bus.req_ready = grant_en ? pick_oh : '0;
        case (state)
            EMPTY: if (grant_en) state_nxt = FULL;
            FULL:  if (bus.out_ready && !grant_en) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            ptr       <= '0;
            hold_data <= '0;
            hold_src  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_en) begin
                hold_data <= bus.req_data[int'(pick_idx)*W +: W];
                hold_src  <= pick_idx;
                ptr       <= (pick_idx == SW'(N-1)) ? '0 : pick_idx + SW'(1);
            end
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = hold_data;
    assign bus.out_src   = hold_src;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Scoreboard bench for dff_share_arbiter: a reference round-robin model predicts
// grants, expected words are queued on grant and popped when the DUT presents them.
module tb_dff_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic reset;

    dff_share_arbiter_if #(.N(N), .W(W)) bus ();

    dff_share_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [SW+W-1:0] sb[$];
    logic            m_full;
    int              m_ptr;
    logic [W-1:0]    m_data;
    logic [SW-1:0]   m_src;
    int              last_grant;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check combinational grant, then check registered outputs.
    task automatic cycle(input logic rst, input logic [N-1:0] vld,
                         input logic [N*W-1:0] dat, input logic ordy);
        logic [N-1:0]    exp_rdy;
        logic [SW+W-1:0] ent;
        int              g;
        int              c;
        reset         = rst;
        bus.req_valid = vld;
        bus.req_data  = dat;
        bus.out_ready = ordy;
        #1;
        g = -1;
        if (!rst && (!m_full || ordy)) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && vld[c]) g = c;
            end
        end
        exp_rdy = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            sb.push_back({SW'(g), dat[g*W +: W]});
        end
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        last_grant = g;
        if (rst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            m_data = '0;
            m_src  = '0;
            sb.delete();
        end else if (g >= 0) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                ent    = sb.pop_front();
                m_src  = ent[SW+W-1:W];
                m_data = ent[W-1:0];
            end
            m_full = 1'b1;
            m_ptr  = (g + 1) % N;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
        chk("out_valid", 32'(bus.out_valid), 32'(m_full));
        chk("out_data",  32'(bus.out_data),  32'(m_data));
        chk("out_src",   32'(bus.out_src),   32'(m_src));
    endtask

    logic [N*W-1:0] rr_dat;
    logic [N*W-1:0] a5_dat;
    logic [N*W-1:0] c3_dat;
    logic [N*W-1:0] rnd_dat;
    logic [W-1:0]   held;

    initial begin
        m_full = 1'b0; m_ptr = 0; m_data = '0; m_src = '0; last_grant = -1;
        rr_dat = {8'h13, 8'h12, 8'h11, 8'h10};
        a5_dat = {8'h00, 8'hA5, 8'h00, 8'h00};
        c3_dat = {N{8'h3C}};
        reset = 1'b1; bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b0;

        // Reset with every requester active: nothing granted, outputs cleared.
        cycle(1'b1, 4'b1111, rr_dat, 1'b0);
        cycle(1'b1, 4'b1111, rr_dat, 1'b0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        cycle(1'b0, 4'b1111, rr_dat, 1'b0);
        chk("first_grant_src", 32'(bus.out_src), 32'd0);
        cycle(1'b0, 4'b0000, rr_dat, 1'b1);
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Single request with consumer stalled.
        cycle(1'b0, 4'b0100, a5_dat, 1'b0);
        chk("single_data", 32'(bus.out_data), 32'h00A5);
        chk("single_src",  32'(bus.out_src),  32'd2);
        repeat (3) cycle(1'b0, 4'b0100, a5_dat, 1'b0);
        chk("single_hold", 32'(bus.out_data), 32'h00A5);
        cycle(1'b0, 4'b0000, a5_dat, 1'b1);

        // Round-robin with same-edge refill, starting from ptr=0.
        cycle(1'b1, 4'b0000, rr_dat, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b1111, rr_dat, 1'b1);
            chk("rr_src",   32'(bus.out_src),  32'(i % N));
            chk("rr_data",  32'(bus.out_data), 32'(8'h10 + (i % N)));
            chk("rr_valid", 32'(bus.out_valid), 32'd1);
        end
        cycle(1'b0, 4'b0000, rr_dat, 1'b1);

        // Wrap: move ptr to 3, then only requester 0, then 3 and 1 together.
        cycle(1'b0, 4'b0100, rr_dat, 1'b1);
        chk("wrap_pre_src", 32'(bus.out_src), 32'd2);
        cycle(1'b0, 4'b0001, rr_dat, 1'b1);
        chk("wrap_src", 32'(bus.out_src), 32'd0);
        cycle(1'b0, 4'b1010, rr_dat, 1'b1);
        chk("wrap_next_src", 32'(bus.out_src), 32'd1);

        // Back-pressure: FULL, consumer stalled, everyone requesting.
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b1111, rr_dat, 1'b0);
            chk("bp_stable", 32'(bus.out_data), 32'(held));
            chk("bp_no_grant", 32'(last_grant + 1), 32'd0);
        end
        cycle(1'b0, 4'b0000, rr_dat, 1'b1);
        chk("bp_drain", 32'(bus.out_valid), 32'd0);

        // Reset while holding 3C discards the word and rewinds ptr.
        cycle(1'b0, 4'b0100, c3_dat, 1'b0);
        chk("mid_full_data", 32'(bus.out_data), 32'h003C);
        cycle(1'b1, 4'b0000, c3_dat, 1'b0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data",  32'(bus.out_data),  32'd0);
        cycle(1'b0, 4'b1111, c3_dat, 1'b0);
        chk("mid_rst_ptr", 32'(bus.out_src), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            rnd_dat = {$urandom, $urandom};
            cycle(($urandom_range(0, 49) == 0), N'($urandom), rnd_dat,
                  1'($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_share_arbiter.md
# dff_share_arbiter

Round-robin arbiter and sequencer that shares one W-bit D-flip-flop holding register among N requesters. It grants one requester at a time, captures that requester's data into the register, and presents the data downstream under a valid/ready handshake. It sits between the per-source D-FF stages and a single downstream consumer that accepts one word at a time.

## Interface
- `N`, default 4: number of requesters; N ≥ 2.
- `W`, default 8: data width in bits.
- `SW`, default $clog2(N): source-index width; derived, not overridden.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  N: bit i means requester i has data.
- `req_data`  in  N*W: requester i's data is on slice [i*W +: W].
- `req_ready`  out  N: one-hot grant. Bit i high means requester i's word is captured at this edge. Combinational.
- `out_valid`  out  1: the holding register is full.
- `out_data`  out  W: contents of the holding register.
- `out_src`  out  SW: index of the requester whose word is held.
- `out_ready`  in  1: the downstream consumer takes the word at this edge.

## Operation
- FSM has two states.
  - EMPTY: the register is free.
  - FULL: the register holds a word.
- `accept` = (state == EMPTY) OR out_ready.
- Grant pick: the first i with req_valid[i]=1, searching from ptr, ptr+1, …, wrapping N-1→0.
- `req_ready[g]` = accept AND any(req_valid), and only for the picked g. All other bits are 0. At most one bit is high.
- On a grant edge:
  - out_data ← req_data[g].
  - out_src ← g.
  - ptr ← (g == N-1) ? 0 : g+1.
  - state ← FULL.
- Rules in FULL:
  - If out_ready=1 and no request: state ← EMPTY. out_data and out_src hold their stale values.
  - If out_ready=1 and a request is present: refill in the same edge and stay FULL. This gives back-to-back throughput of 1 word per cycle.
  - If out_ready=0: hold everything and grant nobody. req_ready is all 0.
- ptr advances only on a grant. Idle cycles do not move it.
- A requester dropping req_valid without being granted is legal and is simply not picked.
- out_ready in EMPTY is ignored.

## Timing
- Reset values, all synchronous: state=EMPTY, ptr=0, out_valid=0, out_data=0, out_src=0.
- req_ready is forced to all 0 while reset=1.
- Reset asserted while FULL discards the held word. The next edge shows out_valid=0.
- Latency: a request granted at edge k gives out_valid=1 with that data after edge k, i.e. in cycle k+1.
- out_valid = (state == FULL), driven directly from the register.
- out_data and out_src change only on grant edges and on reset.
- Combinational paths:
  - out_ready → req_ready.
  - req_valid → req_ready.
  - No path from req_* to out_*.
- Wrap-around: with ptr = N-1 and only req_valid[0] set, the grant goes to 0 and ptr becomes 1.
- Fairness: with all N requesting continuously and out_ready=1, grants follow the order ptr, ptr+1, … and each source gets exactly 1 grant per N cycles.

## Structure
- Package `dff_arb_pkg` holds:
  - the state enum {EMPTY, FULL};
  - the default N and W localparams.
- Sub-module `rr_pick` (combinational) has:
  - inputs: the req vector and ptr;
  - outputs: one-hot grant, encoded index g, and any.
  - It is implemented by doubling the request vector and masking with ptr.
- Top level contains the FSM, ptr, and the holding register (W + SW flops plus the state flop).

## Test plan
- Reset: drive reset=1 for 2 cycles with req_valid=4'b1111.
  - Required: req_ready=0, out_valid=0, out_data=0, out_src=0.
  - After release: the first grant goes to 0.
- Single request: req_valid=4'b0100, req_data[2]=8'hA5, out_ready=0.
  - Required: req_ready=4'b0100 for one cycle, then out_valid=1, out_data=A5, out_src=2.
  - req_ready stays 0 until out_ready=1.
- Round-robin with refill: all four requesting, data = index+0x10, out_ready=1.
  - Required: grants 0,1,2,3,0 on consecutive edges.
  - out_data 10,11,12,13 appears with no bubbles.
- Wrap: sequence ptr to 3, then assert only req_valid[0].
  - Required: grant to 0, then ptr=1.
  - A next request on 3 and 1 together goes to 1.
- Back-pressure and drain: FULL with out_ready=0 for 5 cycles while req_valid=4'b1111.
  - Required: no grants; out_data stable.
  - Then out_ready=1 with req_valid=0 gives state EMPTY and out_valid=0 the next cycle.
- Reset mid-operation: FULL with data 3C; assert reset for 1 cycle.
  - Required: out_valid=0 and out_data=0 on the next edge; ptr=0.
